analyzer_window_sequencer: RTL
==============================

Name: analyzer_window_sequencer

Overview:
Sequences measurement windows for the three-pixel frequency analyzer manager. For each window it generates that block's clear, start and stop controls, then waits for the register write-back interrupt and its release. It supports single, N-repeat and continuous runs, and reports progress, completion and timeout status. It sits between the software-visible control registers and the analyzer manager, on the AXI clock domain.

Parameters:
WINDOW_WIDTH, 32, width of the window-length counter and config.
REPEAT_WIDTH, 16, width of the repeat config and the completed-window counter.
CLEAR_CYCLES, 4, cycles analyzer_clear is held high before each window (≥1).
START_PULSE_CYCLES, 4, nominal high time of analyzer_start (≥1).
IRQ_TIMEOUT, 1024, maximum cycles to wait for each irq edge (≥2).

Ports:
clock  in  1  system clock (AXI clock domain).
reset  in  1  asynchronous, active-high reset.
cmd_start  in  1  single-cycle request to begin a run; sampled only in IDLE.
cmd_abort  in  1  single-cycle request to end the run early.
cfg_window_cycles  in  WINDOW_WIDTH  window length in clocks; latched on start.
cfg_repeat  in  REPEAT_WIDTH  windows per run; latched on start.
cfg_continuous  in  1  run until abort; latched on start.
analyzer_start  out  1  to manager start (rising edge sets enable).
analyzer_stop  out  1  to manager stop (level; triggers write-back).
analyzer_clear  out  1  to manager clear (active-high).
analyzer_irq  in  1  manager irq (write-back completed).
busy  out  1  high in every state except IDLE.
window_done  out  1  one-cycle pulse per completed window.
sequence_done  out  1  one-cycle pulse when a run ends, for any reason.
timeout_error  out  1  sticky flag; cleared on the next accepted cmd_start.
windows_completed  out  REPEAT_WIDTH  windows completed in the current run; cleared on accepted start.

Behaviour:
- All outputs are registered. Reset (async) forces state IDLE, all counters to 0 and all outputs to 0.
- States: IDLE, CLEAR, MEASURE, STOP_WAIT, RELEASE.
- Config latch: cfg_window_cycles=0 is treated as 1. cfg_repeat=0 is treated as 1. cfg_continuous overrides cfg_repeat.
- IDLE: cmd_start at edge k latches the config and enters CLEAR. From cycle k+1, busy=1 and analyzer_clear=1.
- IDLE, cmd_start and cmd_abort in the same cycle: abort wins and the block stays in IDLE.
- cmd_start in any other state is ignored.
- CLEAR: analyzer_clear=1 for exactly CLEAR_CYCLES cycles, then MEASURE.
- MEASURE: lasts exactly W cycles (W = effective window). analyzer_start=1 for the first min(W, START_PULSE_CYCLES) cycles.
- STOP_WAIT: analyzer_stop=1, and a timeout counter runs.
  - analyzer_irq=1 → RELEASE.
  - IRQ_TIMEOUT cycles without irq → set timeout_error, mark the run terminated, go to RELEASE.
- RELEASE: analyzer_stop=0. Wait for analyzer_irq=0, with the timeout counter reloaded.
  - On irq low: if the run was not terminated, increment windows_completed and pulse window_done.
  - Next state is CLEAR if cfg_continuous=1 or windows_completed<repeat, and no abort or timeout is pending. Otherwise IDLE.
  - Timeout in RELEASE: set timeout_error and go straight to IDLE.
  - Any RELEASE→IDLE transition pulses sequence_done in the same cycle busy falls.
- Abort:
  - In CLEAR: go to IDLE next cycle and drop all analyzer outputs. sequence_done pulses, windows_completed is unchanged.
  - In MEASURE: cut the window short, go to STOP_WAIT, and complete write-back. The partial window is not counted, and the run ends after RELEASE.
  - In STOP_WAIT or RELEASE: latched as pending. Write-back completes, the window is counted normally, and the run then ends.
- Counter widths: windows_completed wraps modulo 2^REPEAT_WIDTH in continuous mode. The window counter never exceeds W.
- Output exclusivity: analyzer_start, analyzer_stop and analyzer_clear are never high in the same cycle.

Test Plan:
- W=100, repeat=1, model irq 3 cycles after stop and low 1 cycle after stop drops → clear 4 cycles, start 4 cycles, stop rises exactly 100 cycles after start rises; one window_done and one sequence_done; windows_completed=1.
- repeat=3, W=20 → three clear/start/stop cycles back-to-back; windows_completed=3; sequence_done only after the third; busy stays high throughout.
- irq held low, IRQ_TIMEOUT=1024 → stop high for 1024 cycles, then timeout_error=1, sequence_done pulses, windows_completed=0; the next cmd_start clears timeout_error.
- Continuous, W=10, cmd_abort during the 5th MEASURE → stop asserted the next cycle; windows_completed=4; IDLE after irq release.
- cmd_abort and cmd_start in the same cycle in IDLE → stays in IDLE, no outputs. W=0 and W=2 → a 1- or 2-cycle window, with start high only for those cycles.
- Async reset asserted mid-STOP_WAIT → all outputs 0 immediately, state IDLE; after release, a fresh cmd_start runs normally.

Source files
------------

// File: rtl/analyzer_window_sequencer.sv
// analyzer_window_sequencer
//
// Runs measurement windows for the three-pixel frequency analyzer manager.
// Each window clears the analyzer, pulses start, holds the measurement
// open for the configured number of clocks, raises stop to request a
// register write-back, and then waits for the write-back interrupt to
// rise and fall again. A run can be a single window, N windows, or
// continuous until aborted. Lives on the AXI clock domain.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   cmd_start, cmd_abort  single-cycle run start / abort requests
//   cfg_window_cycles     window length in clocks (0 behaves as 1)
//   cfg_repeat            windows per run (0 behaves as 1)
//   cfg_continuous        run until abort, ignoring cfg_repeat
//   analyzer_start/stop/clear  controls to the analyzer manager
//   analyzer_irq          write-back complete from the manager
//   busy                  high whenever a run is in progress
//   window_done           one-cycle pulse per counted window
//   sequence_done         one-cycle pulse when a run ends
//   timeout_error         sticky, cleared by the next accepted start
//   windows_completed     windows counted in the current run

`default_nettype none

module analyzer_window_sequencer #(
    parameter int WINDOW_WIDTH       = 32,
    parameter int REPEAT_WIDTH       = 16,
    parameter int CLEAR_CYCLES       = 4,
    parameter int START_PULSE_CYCLES = 4,
    parameter int IRQ_TIMEOUT        = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic                    cmd_abort,
    input  logic [WINDOW_WIDTH-1:0] cfg_window_cycles,
    input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
    input  logic                    cfg_continuous,
    output logic                    analyzer_start,
    output logic                    analyzer_stop,
    output logic                    analyzer_clear,
    input  logic                    analyzer_irq,
    output logic                    busy,
    output logic                    window_done,
    output logic                    sequence_done,
    output logic                    timeout_error,
    output logic [REPEAT_WIDTH-1:0] windows_completed
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_MEASURE   = 3'd2;
    localparam logic [2:0] S_STOP_WAIT = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    localparam int TO_W = (IRQ_TIMEOUT > 2) ? $clog2(IRQ_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]         TO_LAST    = TO_W'(IRQ_TIMEOUT - 1);
    localparam logic [WINDOW_WIDTH-1:0] CLEAR_LAST = WINDOW_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [WINDOW_WIDTH-1:0] START_LEN  = WINDOW_WIDTH'(START_PULSE_CYCLES);

    logic [2:0]              state;
    logic [WINDOW_WIDTH-1:0] cnt;          // phase counter for CLEAR and MEASURE
    logic [TO_W-1:0]         tcnt;         // irq edge timeout counter
    logic                    terminated;   // current window must not be counted
    logic                    abort_pending;

    // Run configuration, captured on an accepted start.
    logic [WINDOW_WIDTH-1:0] win_len;
    logic [REPEAT_WIDTH-1:0] rep_len;
    logic                    run_cont;

    logic                    accept_start;
    logic [WINDOW_WIDTH-1:0] cnt_inc;
    logic [WINDOW_WIDTH-1:0] win_last;
    logic [REPEAT_WIDTH:0]   wc_inc;       // one bit wider so the repeat compare cannot wrap
    logic [REPEAT_WIDTH:0]   rep_ext;

    assign accept_start = (state == S_IDLE) && cmd_start && !cmd_abort;
    assign cnt_inc      = cnt + 1'b1;
    assign win_last     = win_len - 1'b1;
    assign wc_inc       = {1'b0, windows_completed} + 1'b1;
    assign rep_ext      = {1'b0, rep_len};

    // Configuration holds data only, so it carries no reset.
    always_ff @(posedge clock) begin
        if (accept_start) begin
            win_len  <= (cfg_window_cycles == '0) ? WINDOW_WIDTH'(1) : cfg_window_cycles;
            rep_len  <= (cfg_repeat == '0) ? REPEAT_WIDTH'(1) : cfg_repeat;
            run_cont <= cfg_continuous;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            tcnt              <= '0;
            terminated        <= 1'b0;
            abort_pending     <= 1'b0;
            analyzer_start    <= 1'b0;
            analyzer_stop     <= 1'b0;
            analyzer_clear    <= 1'b0;
            busy              <= 1'b0;
            window_done       <= 1'b0;
            sequence_done     <= 1'b0;
            timeout_error     <= 1'b0;
            windows_completed <= '0;
        end else begin
            window_done   <= 1'b0;
            sequence_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_start) begin
                        state             <= S_CLEAR;
                        cnt               <= '0;
                        terminated        <= 1'b0;
                        abort_pending     <= 1'b0;
                        timeout_error     <= 1'b0;
                        windows_completed <= '0;
                        busy              <= 1'b1;
                        analyzer_clear    <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    if (cmd_abort) begin
                        state          <= S_IDLE;
                        analyzer_clear <= 1'b0;
                        busy           <= 1'b0;
                        sequence_done  <= 1'b1;
                    end else if (cnt == CLEAR_LAST) begin
                        state          <= S_MEASURE;
                        cnt            <= '0;
                        analyzer_clear <= 1'b0;
                        analyzer_start <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_MEASURE: begin
                    // An abort cuts the window short; write-back still runs so the
                    // manager is left consistent, but the window is not counted.
                    if (cmd_abort || (cnt == win_last)) begin
                        state          <= S_STOP_WAIT;
                        cnt            <= '0;
                        tcnt           <= '0;
                        analyzer_start <= 1'b0;
                        analyzer_stop  <= 1'b1;
                        if (cmd_abort) begin
                            terminated <= 1'b1;
                        end
                    end else begin
                        cnt            <= cnt_inc;
                        analyzer_start <= (cnt_inc < START_LEN);
                    end
                end

                S_STOP_WAIT: begin
                    if (cmd_abort) begin
                        abort_pending <= 1'b1;
                    end
                    if (analyzer_irq) begin
                        state         <= S_RELEASE;
                        tcnt          <= '0;
                        analyzer_stop <= 1'b0;
                    end else if (tcnt == TO_LAST) begin
                        state         <= S_RELEASE;
                        tcnt          <= '0;
                        analyzer_stop <= 1'b0;
                        timeout_error <= 1'b1;
                        terminated    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (cmd_abort) begin
                        abort_pending <= 1'b1;
                    end
                    if (!analyzer_irq) begin
                        if (!terminated) begin
                            windows_completed <= wc_inc[REPEAT_WIDTH-1:0];
                            window_done       <= 1'b1;
                        end
                        if (!terminated && !abort_pending && !cmd_abort &&
                            (run_cont || (wc_inc < rep_ext))) begin
                            state          <= S_CLEAR;
                            cnt            <= '0;
                            analyzer_clear <= 1'b1;
                        end else begin
                            state         <= S_IDLE;
                            busy          <= 1'b0;
                            sequence_done <= 1'b1;
                        end
                    end else if (tcnt == TO_LAST) begin
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        sequence_done <= 1'b1;
                        timeout_error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    analyzer_start <= 1'b0;
                    analyzer_stop  <= 1'b0;
                    analyzer_clear <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
